// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared UART definitions: default widths for the baud generator and the
//   divisor record exchanged between the CSR block and the RX/TX engines.
//   No ports; imported by baud_rate_gen and its sub-blocks.
package uart_pkg;

    localparam int UART_DIV_W      = 16;
    localparam int UART_FRAC_W     = 4;
    localparam int UART_OVERSAMPLE = 16;

    // Divisor as programmed by software: base period D+1 cycles plus F/2**FRAC_W.
    typedef struct packed {
        logic [UART_DIV_W-1:0]  div_int;
        logic [UART_FRAC_W-1:0] div_frac;
    } baud_div_t;

endpackage

// File: rtl/frac_period_counter.sv
// frac_period_counter
//   Fractional-N period counter. Counts 0..limit and pulses wrap on the last
//   cycle of each period. limit is D, stretched to D+1 whenever the previous
//   wrap overflowed the fractional accumulator, so the mean period is
//   D+1+F/2**FRAC_W cycles.
// Ports
//   clk, reset      clock, synchronous active-high reset
//   en              1 = count; 0 = hold cnt/acc/stretch, no wrap
//   clr             restart phase: cnt, acc, stretch <= 0, no wrap this cycle
//   div_int         integer divisor D (active value from the top level)
//   div_frac        fractional divisor F
//   wrap            combinational: this cycle ends the current period
module frac_period_counter
    import uart_pkg::*;
#(
    parameter int DIV_W  = UART_DIV_W,
    parameter int FRAC_W = UART_FRAC_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              clr,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              wrap
);

    // One extra bit so D = 2**DIV_W-1 plus stretch still fits.
    logic [DIV_W:0]  cnt;
    logic [DIV_W:0]  limit;
    logic [FRAC_W-1:0] acc;
    logic [FRAC_W:0]   acc_sum;
    logic              stretch;

    assign limit   = {1'b0, div_int} + {{DIV_W{1'b0}}, stretch};
    assign acc_sum = {1'b0, acc} + {1'b0, div_frac};

    // >= rather than ==: a divisor applied while held may be shorter than the
    // count already reached; the period then ends on the next enabled cycle.
    assign wrap = !reset && !clr && en && (cnt >= limit);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt     <= '0;
            acc     <= '0;
            stretch <= 1'b0;
        end else if (wrap) begin
            cnt     <= '0;
            acc     <= acc_sum[FRAC_W-1:0];
            stretch <= acc_sum[FRAC_W];
        end else if (en) begin
            cnt <= cnt + (DIV_W+1)'(1);
        end
    end

endmodule

// File: rtl/baud_rate_gen.sv
// baud_rate_gen
//   Fractional-N baud generator for the UART TX/RX engines. Produces an
//   oversample tick, a bit-centre tick and a bit-end tick.
// Ports
//   clk, reset   clock, synchronous active-high reset
//   en           1 = run; 0 = hold all counters, suppress ticks
//   sync_clr     pulse: restart phase (period counter, accumulator, os_cnt)
//   div_load     pulse: capture div_int/div_frac as the pending divisor
//   div_int      integer divisor D (base period D+1 cycles)
//   div_frac     fractional divisor F (units of 1/2**FRAC_W cycle)
//   tick         oversample tick, registered 1-cycle pulse
//   mid_tick     with tick when os_cnt was OVERSAMPLE/2-1 at the wrap
//   bit_tick     with tick when os_cnt was OVERSAMPLE-1 at the wrap
//   div_pend     a loaded divisor is waiting to be applied
module baud_rate_gen
    import uart_pkg::*;
#(
    parameter int DIV_W      = UART_DIV_W,
    parameter int FRAC_W     = UART_FRAC_W,
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int RESET_INT  = 325,
    parameter int RESET_FRAC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              sync_clr,
    input  logic              div_load,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              tick,
    output logic              mid_tick,
    output logic              bit_tick,
    output logic              div_pend
);

    localparam int OS_W = $clog2(OVERSAMPLE);

    logic [DIV_W-1:0]  act_int;
    logic [FRAC_W-1:0] act_frac;
    logic [DIV_W-1:0]  pend_int;
    logic [FRAC_W-1:0] pend_frac;
    logic [OS_W-1:0]   os_cnt;
    logic              wrap;
    logic              apply;

    frac_period_counter #(
        .DIV_W  (DIV_W),
        .FRAC_W (FRAC_W)
    ) u_period (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .clr      (sync_clr),
        .div_int  (act_int),
        .div_frac (act_frac),
        .wrap     (wrap)
    );

    // Swap only at a period boundary so a running bit never sees a mixed
    // divisor; while held there is no boundary to wait for.
    assign apply = div_pend && (wrap || !en);

    always_ff @(posedge clk) begin
        if (reset) begin
            act_int   <= DIV_W'(RESET_INT);
            act_frac  <= FRAC_W'(RESET_FRAC);
            pend_int  <= '0;
            pend_frac <= '0;
            div_pend  <= 1'b0;
            os_cnt    <= '0;
            tick      <= 1'b0;
            mid_tick  <= 1'b0;
            bit_tick  <= 1'b0;
        end else if (sync_clr) begin
            // Pending divisor survives the realign and is not applied by it.
            os_cnt   <= '0;
            tick     <= 1'b0;
            mid_tick <= 1'b0;
            bit_tick <= 1'b0;
        end else begin
            tick     <= wrap;
            mid_tick <= wrap && (os_cnt == OS_W'(OVERSAMPLE/2 - 1));
            bit_tick <= wrap && (os_cnt == OS_W'(OVERSAMPLE - 1));
            // OVERSAMPLE is a power of two, so natural overflow is the modulo.
            if (wrap) begin
                os_cnt <= os_cnt + OS_W'(1);
            end
            if (apply) begin
                act_int  <= pend_int;
                act_frac <= pend_frac;
            end
            // A load coinciding with an apply becomes the next pending value.
            if (div_load) begin
                pend_int  <= div_int;
                pend_frac <= div_frac;
                div_pend  <= 1'b1;
            end else if (apply) begin
                div_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_baud_rate_gen.sv
module tb_baud_rate_gen;

    localparam int DIV_W = 16;
    localparam int FRAC_W = 4;
    localparam int OS = 16;
    localparam int RI = 325;
    localparam int RF = 0;

    logic clk = 1'b0;
    logic reset, en, sync_clr, div_load;
    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic tick, mid_tick, bit_tick, div_pend;

    always #5 clk = ~clk;

    baud_rate_gen #(
        .DIV_W(DIV_W), .FRAC_W(FRAC_W), .OVERSAMPLE(OS),
        .RESET_INT(RI), .RESET_FRAC(RF)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .sync_clr(sync_clr),
        .div_load(div_load), .div_int(div_int), .div_frac(div_frac),
        .tick(tick), .mid_tick(mid_tick), .bit_tick(bit_tick),
        .div_pend(div_pend)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit chk_on = 1'b0;

    always @(posedge clk) cyc++;

    // Reference model: elapsed enabled cycles in the current period against
    // its length D+1+stretch; stretch is the integer part of the running
    // fractional sum.
    int m_el = 0, m_acc = 0, m_str = 0, m_os = 0;
    int m_ad = RI, m_af = RF, m_pd = 0, m_pf = 0;
    bit m_pend = 0, e_tick = 0, e_mid = 0, e_bit = 0;

    always @(posedge clk) begin
        bit w, ap;
        int s;
        if (reset) begin
            m_el = 0; m_acc = 0; m_str = 0; m_os = 0;
            m_ad = RI; m_af = RF; m_pend = 0;
            e_tick = 0; e_mid = 0; e_bit = 0;
        end else if (sync_clr) begin
            m_el = 0; m_acc = 0; m_str = 0; m_os = 0;
            e_tick = 0; e_mid = 0; e_bit = 0;
        end else begin
            w = en && (m_el + 1 >= m_ad + 1 + m_str);
            e_tick = w;
            e_mid = w && (m_os == OS/2 - 1);
            e_bit = w && (m_os == OS - 1);
            ap = m_pend && (w || !en);
            if (w) begin
                s = m_acc + m_af;
                m_str = s / (1 << FRAC_W);
                m_acc = s % (1 << FRAC_W);
                m_el = 0;
                m_os = (m_os + 1) % OS;
            end else if (en) begin
                m_el++;
            end
            if (ap) begin
                m_ad = m_pd; m_af = m_pf;
            end
            if (div_load) begin
                m_pd = int'(div_int); m_pf = int'(div_frac); m_pend = 1;
            end else if (ap) begin
                m_pend = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            vectors++;
            if ({tick, mid_tick, bit_tick, div_pend} !== {e_tick, e_mid, e_bit, m_pend}) begin
                miscompares++;
                $display("FAIL model_cycle %0d: got tick/mid/bit/pend=%b required %b",
                         cyc, {tick, mid_tick, bit_tick, div_pend}, {e_tick, e_mid, e_bit, m_pend});
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic wait_tick(output int t);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick && n < 5000);
        if (!tick) begin
            vectors++;
            miscompares++;
            $display("FAIL tick_timeout: no tick within %0d cycles", n);
        end
        t = cyc;
    endtask

    // Hold, load, let it apply while held, realign, run.
    task automatic program_div(input int d, input int f);
        @(negedge clk);
        en = 1'b0; div_load = 1'b1;
        div_int = DIV_W'(d); div_frac = FRAC_W'(f);
        @(negedge clk);
        div_load = 1'b0;
        @(negedge clk);
        sync_clr = 1'b1;
        @(negedge clk);
        sync_clr = 1'b0; en = 1'b1;
    endtask

    typedef struct {
        int d;
        int f;
        int nticks;
        int span;
    } row_t;

    row_t rows[5];

    initial begin
        int t0, t1, t2, n;
        rows[0] = '{3, 0, 16, 64};
        rows[1] = '{3, 8, 32, 144};
        rows[2] = '{0, 0, 10, 10};
        rows[3] = '{1, 4, 16, 36};
        rows[4] = '{5, 15, 16, 111};

        reset = 1'b1; en = 1'b0; sync_clr = 1'b0; div_load = 1'b0;
        div_int = '0; div_frac = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", int'({tick, mid_tick, bit_tick, div_pend}), 0);
        chk_on = 1'b1;
        reset = 1'b0; en = 1'b1;

        // Span of N tick intervals for several divisors.
        for (int i = 0; i < 5; i++) begin
            program_div(rows[i].d, rows[i].f);
            wait_tick(t0);
            for (int k = 0; k < rows[i].nticks; k++) wait_tick(t1);
            check($sformatf("span_d%0d_f%0d", rows[i].d, rows[i].f), t1 - t0, rows[i].span);
        end

        // mid_tick 32 cycles after bit_tick, bit_tick every 64.
        program_div(3, 0);
        n = 0;
        do begin wait_tick(t0); n++; end while (!bit_tick && n < 40);
        n = 0;
        do begin wait_tick(t1); n++; end while (!mid_tick && n < 40);
        n = 0;
        do begin wait_tick(t2); n++; end while (!bit_tick && n < 40);
        check("mid_after_bit", t1 - t0, 32);
        check("bit_period", t2 - t0, 64);

        // Load mid-period: current interval unchanged, next uses new divisor.
        program_div(9, 0);
        wait_tick(t0);
        repeat (3) @(negedge clk);
        div_load = 1'b1; div_int = 16'd4; div_frac = 4'd0;
        @(negedge clk);
        div_load = 1'b0;
        check("pend_after_load", int'(div_pend), 1);
        wait_tick(t1);
        check("load_cur_interval", t1 - t0, 10);
        check("pend_cleared_at_wrap", int'(div_pend), 0);
        wait_tick(t2);
        check("load_next_interval", t2 - t1, 5);

        // Hold for 7 cycles inside a period.
        program_div(9, 0);
        wait_tick(t0);
        repeat (3) @(negedge clk);
        en = 1'b0;
        repeat (7) @(negedge clk);
        en = 1'b1;
        wait_tick(t1);
        check("hold_interval", t1 - t0, 17);

        // Realign at os_cnt = 9.
        program_div(3, 0);
        repeat (9) wait_tick(t0);
        @(negedge clk);
        sync_clr = 1'b1;
        @(negedge clk);
        sync_clr = 1'b0;
        t0 = cyc;
        wait_tick(t1);
        check("sync_clr_first_tick", t1 - t0, 4);
        n = 1;
        while (!bit_tick && n < 40) begin wait_tick(t2); n++; end
        check("sync_clr_bit_index", n, 16);

        // Reset with a load pending.
        program_div(3, 0);
        wait_tick(t0);
        div_load = 1'b1; div_int = 16'd7; div_frac = 4'd3;
        @(negedge clk);
        div_load = 1'b0;
        check("pend_before_reset", int'(div_pend), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("reset_midrun_outputs", int'({tick, mid_tick, bit_tick, div_pend}), 0);
        t0 = cyc;
        wait_tick(t1);
        check("reset_first_period", t1 - t0, RI + 1);
        wait_tick(t2);
        check("reset_second_period", t2 - t1, RI + 1);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            reset    = ($urandom_range(0, 299) == 0);
            sync_clr = ($urandom_range(0, 59) == 0);
            en       = ($urandom_range(0, 99) < 85);
            div_load = ($urandom_range(0, 19) == 0);
            div_int  = DIV_W'($urandom_range(0, 6));
            div_frac = FRAC_W'($urandom_range(0, 15));
        end
        @(negedge clk);
        reset = 1'b0; sync_clr = 1'b0; div_load = 1'b0; en = 1'b1;
        repeat (20) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
